dice_roll_controller: RTL and testbench

Sequences one die roll for the board's 7-segment-style dice display. It detects a debounced button release and steps the displayed number through 1..6 at a slowing rate (the "tumble"). It then loads the final value from the free-running 1..6 counter and blinks it, holds it, and blanks the display after an idle timeout. It sits between the debounce block / free-running counter and the number-to-dice decoder, replacing the direct latch.

---
 rtl/dice_roll_if.sv | 28 ++
 rtl/dice_roll_controller.sv | 165 ++++++++++++++++
 tb/tb_dice_roll_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dice_roll_if.sv
// Signal bundle between the debounce/free-running counter side and the dice
// roll sequencer, with the number/blank outputs feeding the dice decoder.
interface dice_roll_if;
    logic       i_Switch;
    logic [2:0] i_Rand;
    logic [2:0] o_Number;
    logic       o_Blank;
    logic       o_Rolling;
    logic       o_Done;

    modport master (
        output i_Switch,
        output i_Rand,
        input  o_Number,
        input  o_Blank,
        input  o_Rolling,
        input  o_Done
    );

    modport slave (
        input  i_Switch,
        input  i_Rand,
        output o_Number,
        output o_Blank,
        output o_Rolling,
        output o_Done
    );
endinterface

// File: rtl/dice_roll_controller.sv
// Dice roll sequencer: on button release, tumbles 1..6 at a slowing rate, loads
// the free-running value, blinks it, holds it, and blanks after an idle timeout.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_SHOW  | number shown steadily, idle timer running toward blanking
// ST_IDLE  | display dark after idle timeout, number retained
// ST_ROLL  | tumble: number advances at the end of each lengthening interval
// ST_BLINK | final number blinks for 2*BLINKS half-periods, starting dark
module dice_roll_controller #(
    parameter int CNT_W        = 28,
    parameter int STEP_START   = 1250000,
    parameter int STEP_INC     = 250000,
    parameter int NUM_STEPS    = 12,
    parameter int BLINK_HALF   = 2500000,
    parameter int BLINKS       = 3,
    parameter int IDLE_TIMEOUT = 250000000
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    dice_roll_if.slave    dice
);

    localparam int K_W = (NUM_STEPS < 2) ? 1 : $clog2(NUM_STEPS + 1);
    localparam int H_W = (BLINKS < 2) ? 1 : $clog2(2 * BLINKS);

    typedef enum logic [1:0] {
        ST_SHOW  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ROLL  = 2'd2,
        ST_BLINK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             sw_q;
    logic [2:0]       num_q, num_d;
    logic             blank_q, blank_d;
    logic             done_q, done_d;
    logic             rolling_q, rolling_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0] step_tmr_q, step_tmr_d;
    logic [CNT_W-1:0] step_len_q, step_len_d;
    logic [K_W-1:0]   step_k_q, step_k_d;
    logic [CNT_W-1:0] blink_tmr_q, blink_tmr_d;
    logic [H_W-1:0]   half_q, half_d;
    logic             release_w;
    logic [2:0]       num_adv;
    logic [2:0]       rand_fix;

    assign release_w = sw_q & ~dice.i_Switch;
    assign num_adv   = (num_q >= 3'd6 || num_q == 3'd0) ? 3'd1 : num_q + 3'd1;
    assign rand_fix  = (dice.i_Rand == 3'd0 || dice.i_Rand == 3'd7) ? 3'd1 : dice.i_Rand;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_SHOW;
            sw_q        <= 1'b0;
            num_q       <= 3'd6;
            blank_q     <= 1'b0;
            done_q      <= 1'b0;
            rolling_q   <= 1'b0;
            idle_q      <= '0;
            step_tmr_q  <= '0;
            step_len_q  <= '0;
            step_k_q    <= '0;
            blink_tmr_q <= '0;
            half_q      <= '0;
        end else begin
            state_q     <= state_d;
            sw_q        <= dice.i_Switch;
            num_q       <= num_d;
            blank_q     <= blank_d;
            done_q      <= done_d;
            rolling_q   <= rolling_d;
            idle_q      <= idle_d;
            step_tmr_q  <= step_tmr_d;
            step_len_q  <= step_len_d;
            step_k_q    <= step_k_d;
            blink_tmr_q <= blink_tmr_d;
            half_q      <= half_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        blank_d     = blank_q;
        done_d      = 1'b0;
        idle_d      = idle_q;
        step_tmr_d  = step_tmr_q;
        step_len_d  = step_len_q;
        step_k_d    = step_k_q;
        blink_tmr_d = blink_tmr_q;
        half_d      = half_q;

        case (state_q)
            ST_SHOW, ST_IDLE: begin
                if (state_q == ST_SHOW) begin
                    blank_d = 1'b0;
                    idle_d  = idle_q + CNT_W'(1);
                end else begin
                    blank_d = 1'b1;
                end
                // A release always beats the idle timeout in the same cycle.
                if (release_w) begin
                    state_d    = ST_ROLL;
                    num_d      = num_adv;
                    blank_d    = 1'b0;
                    step_k_d   = K_W'(1);
                    step_len_d = CNT_W'(STEP_START);
                    step_tmr_d = CNT_W'(STEP_START - 1);
                end else if (state_q == ST_SHOW && idle_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    blank_d = 1'b1;
                end
            end

            ST_ROLL: begin
                if (step_tmr_q == '0) begin
                    if (step_k_q == K_W'(NUM_STEPS)) begin
                        state_d     = ST_BLINK;
                        num_d       = rand_fix;
                        blank_d     = 1'b1;
                        blink_tmr_d = '0;
                        half_d      = '0;
                    end else begin
                        num_d      = num_adv;
                        step_k_d   = step_k_q + K_W'(1);
                        step_len_d = step_len_q + CNT_W'(STEP_INC);
                        step_tmr_d = step_len_q + CNT_W'(STEP_INC) - CNT_W'(1);
                    end
                end else begin
                    step_tmr_d = step_tmr_q - CNT_W'(1);
                end
            end

            ST_BLINK: begin
                if (blink_tmr_q == CNT_W'(BLINK_HALF - 1)) begin
                    blink_tmr_d = '0;
                    if (half_q == H_W'(2 * BLINKS - 1)) begin
                        state_d = ST_SHOW;
                        blank_d = 1'b0;
                        done_d  = 1'b1;
                        idle_d  = '0;
                    end else begin
                        half_d  = half_q + H_W'(1);
                        blank_d = ~blank_q;
                    end
                end else begin
                    blink_tmr_d = blink_tmr_q + CNT_W'(1);
                end
            end

            default: state_d = ST_SHOW;
        endcase

        rolling_d = (state_d == ST_ROLL) || (state_d == ST_BLINK);
    end

    assign dice.o_Number  = num_q;
    assign dice.o_Blank   = blank_q;
    assign dice.o_Done    = done_q;
    assign dice.o_Rolling = rolling_q;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Directed bench for dice_roll_controller using a shortened timing set so the
// full tumble/blink/idle cycle fits in a few dozen clocks.
module tb_dice_roll_controller;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    dice_roll_if dif ();

    dice_roll_controller #(
        .CNT_W        (28),
        .STEP_START   (4),
        .STEP_INC     (2),
        .NUM_STEPS    (3),
        .BLINK_HALF   (3),
        .BLINKS       (2),
        .IDLE_TIMEOUT (20)
    ) u_dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .dice    (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] adv(input logic [2:0] n);
        return (n == 3'd6) ? 3'd1 : n + 3'd1;
    endfunction

    // Cycle j is j clocks after the release cycle N.
    task automatic run_roll(input logic [2:0] start, input logic [2:0] rnd,
                            input logic [2:0] fin, input bit extra);
        logic [2:0] n1, n2, n3, e_num;
        int         e_blank, e_roll, e_done;
        n1 = adv(start);
        n2 = adv(n1);
        n3 = adv(n2);
        dif.i_Rand   = rnd;
        dif.i_Switch = 1'b1;
        tick();
        dif.i_Switch = 1'b0;
        for (int j = 1; j <= 31; j++) begin
            tick();
            if (extra && (j == 2 || j == 19)) dif.i_Switch = 1'b1;
            if (extra && (j == 3 || j == 20)) dif.i_Switch = 1'b0;
            if (j < 5)       e_num = n1;
            else if (j < 11) e_num = n2;
            else if (j < 19) e_num = n3;
            else             e_num = fin;
            e_blank = ((j >= 19 && j <= 21) || (j >= 25 && j <= 27)) ? 1 : 0;
            e_roll  = (j <= 30) ? 1 : 0;
            e_done  = (j == 31) ? 1 : 0;
            chk($sformatf("number@N+%0d", j),  int'(dif.o_Number),  int'(e_num));
            chk($sformatf("blank@N+%0d", j),   int'(dif.o_Blank),   e_blank);
            chk($sformatf("rolling@N+%0d", j), int'(dif.o_Rolling), e_roll);
            chk($sformatf("done@N+%0d", j),    int'(dif.o_Done),    e_done);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        dif.i_Switch = 1'b0;
        dif.i_Rand   = 3'd4;

        #12;
        chk("rst_number", int'(dif.o_Number),  6);
        chk("rst_blank",  int'(dif.o_Blank),   0);
        chk("rst_roll",   int'(dif.o_Rolling), 0);
        chk("rst_done",   int'(dif.o_Done),    0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_number", int'(dif.o_Number), 6);
        chk("post_rst_blank",  int'(dif.o_Blank),  0);

        // Basic roll from 6, final value 4.
        run_roll(3'd6, 3'd4, 3'd4, 1'b0);
        // Extra releases ignored; out-of-range random 7 clamps to 1.
        run_roll(3'd4, 3'd7, 3'd1, 1'b1);
        // Random 0 clamps to 1.
        run_roll(3'd1, 3'd0, 3'd1, 1'b0);

        // Idle timeout: idle timer restarts at the done cycle.
        for (int i = 1; i <= 19; i++) begin
            tick();
            chk($sformatf("show_blank@%0d", i), int'(dif.o_Blank), 0);
        end
        tick();
        chk("idle_blank",  int'(dif.o_Blank),   1);
        chk("idle_number", int'(dif.o_Number),  1);
        chk("idle_roll",   int'(dif.o_Rolling), 0);
        repeat (3) tick();
        chk("idle_hold_blank", int'(dif.o_Blank), 1);

        // Release from IDLE starts a roll advancing from the held value.
        dif.i_Switch = 1'b1;
        tick();
        dif.i_Switch = 1'b0;
        tick();
        chk("idle_roll_number", int'(dif.o_Number),  2);
        chk("idle_roll_blank",  int'(dif.o_Blank),   0);
        chk("idle_roll_active", int'(dif.o_Rolling), 1);

        // Asynchronous reset mid-roll, between clock edges.
        repeat (2) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_number", int'(dif.o_Number),  6);
        chk("async_rst_blank",  int'(dif.o_Blank),   0);
        chk("async_rst_roll",   int'(dif.o_Rolling), 0);
        chk("async_rst_done",   int'(dif.o_Done),    0);
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk($sformatf("no_done@%0d", i),   int'(dif.o_Done),   0);
            chk($sformatf("hold_num@%0d", i),  int'(dif.o_Number), 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
